// File: rtl/rcv_bit_timer.sv
// rtl/rcv_bit_timer.sv - receive bit timer: per-bit sample strobe, bit counter and packet-done pulse
// Counters roll 1..CLKS_PER_BIT while running; outputs decode registered state only.
module rcv_bit_timer #(
  parameter int CLKS_PER_BIT    = 10,
  parameter int SAMPLE_POINT    = 5,
  parameter int BITS_PER_PACKET = 10
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 enable_timer,
  output logic                                 shift_strobe,
  output logic                                 packet_done,
  output logic [$clog2(BITS_PER_PACKET+1)-1:0] bit_index
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int BW = $clog2(BITS_PER_PACKET + 1);

  localparam logic [CW-1:0] CLK_LAST   = CW'(CLKS_PER_BIT);
  localparam logic [CW-1:0] CLK_SAMPLE = CW'(SAMPLE_POINT);
  localparam logic [BW-1:0] BIT_LAST   = BW'(BITS_PER_PACKET - 1);
  localparam logic [BW-1:0] BIT_FULL   = BW'(BITS_PER_PACKET);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      IDLE: begin
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        if (enable_timer) begin
          state_d   = RUN;
          clk_cnt_d = CW'(1);
        end
      end
      RUN: begin
        // Losing enable wins over a strobe landing on the same edge.
        if (!enable_timer) begin
          state_d   = IDLE;
          clk_cnt_d = '0;
          bit_cnt_d = '0;
        end else begin
          clk_cnt_d = (clk_cnt_q == CLK_LAST) ? CW'(1) : clk_cnt_q + CW'(1);
          if (shift_strobe) begin
            if (bit_cnt_q == BIT_LAST) begin
              state_d   = DONE;
              bit_cnt_d = BIT_FULL;
              clk_cnt_d = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + BW'(1);
            end
          end
        end
      end
      DONE: begin
        state_d   = IDLE;
        clk_cnt_d = '0;
        bit_cnt_d = '0;
      end
      default: begin
        state_d   = IDLE;
        clk_cnt_d = '0;
        bit_cnt_d = '0;
      end
    endcase
  end

  assign shift_strobe = (state_q == RUN) && (clk_cnt_q == CLK_SAMPLE);
  assign packet_done  = (state_q == DONE);
  assign bit_index    = bit_cnt_q;

endmodule

// File: tb/tb_rcv_bit_timer.sv
// tb/tb_rcv_bit_timer.sv - self-checking bench for rcv_bit_timer (default and small-parameter instances)
// Reference tracks edges elapsed since packet start; outputs follow from timing arithmetic.
module tb_rcv_bit_timer;

  logic       clk;
  logic       rst;
  logic       en0, en1;
  logic       s0, dn0, s1, dn1;
  logic [3:0] i0;
  logic [1:0] i1;
  logic [9:0] obs0, obs1;
  int         ph0, ph1;
  int         total, bad;

  rcv_bit_timer #(.CLKS_PER_BIT(10), .SAMPLE_POINT(5), .BITS_PER_PACKET(10)) u_def (
    .clk(clk), .rst(rst), .enable_timer(en0),
    .shift_strobe(s0), .packet_done(dn0), .bit_index(i0)
  );

  rcv_bit_timer #(.CLKS_PER_BIT(4), .SAMPLE_POINT(4), .BITS_PER_PACKET(3)) u_small (
    .clk(clk), .rst(rst), .enable_timer(en1),
    .shift_strobe(s1), .packet_done(dn1), .bit_index(i1)
  );

  assign obs0 = {s0, dn0, 4'b0, i0};
  assign obs1 = {s1, dn1, 6'b0, i1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // p = edges since the packet's first enabled edge, -1 when idle
  function automatic int next_phase(int p, logic en, int cpb, int sp, int bpp);
    int d;
    d = sp + (bpp - 1) * cpb;
    if (p < 0) return en ? 0 : -1;
    if (p == d || !en) return -1;
    return p + 1;
  endfunction

  function automatic logic [9:0] exp_out(int p, int cpb, int sp, int bpp);
    int d, idx;
    logic s, dn;
    d = sp + (bpp - 1) * cpb;
    s = 1'b0; dn = 1'b0; idx = 0;
    if (p >= 0) begin
      if (p == d) begin
        dn = 1'b1; idx = bpp;
      end else begin
        s   = (p >= sp - 1) && (((p - (sp - 1)) % cpb) == 0);
        idx = (p < sp) ? 0 : (p - sp) / cpb + 1;
      end
    end
    return {s, dn, idx[7:0]};
  endfunction

  function automatic logic [9:0] exp0();
    return exp_out(ph0, 10, 5, 10);
  endfunction

  function automatic logic [9:0] exp1();
    return exp_out(ph1, 4, 4, 3);
  endfunction

  task automatic tick(input logic e0, input logic e1);
    en0 = e0;
    en1 = e1;
    @(posedge clk);
    ph0 = next_phase(ph0, e0, 10, 5, 10);
    ph1 = next_phase(ph1, e1, 4, 4, 3);
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (6) tick(1'b1, 1'b1);
    #2 rst = 1'b1;
    ph0 = -1; ph1 = -1;
    #1;
    total++;
    if (obs0 !== 10'd0 || obs1 !== 10'd0) begin
      bad++;
      $display("FAIL reset_async got=%h/%h want=000/000", obs0, obs1);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick(1'b0, 1'b0);
      total++;
      if (obs0 !== 10'd0 || obs1 !== 10'd0) begin
        bad++;
        $display("FAIL reset_idle c=%0d got=%h/%h want=000/000", c, obs0, obs1);
      end
    end
  endtask

  task automatic test_full_packet();
    logic en;
    int   strobes[$];
    int   done_at;
    bit   fin;
    en = 1'b1; done_at = -1; fin = 1'b0;
    for (int c = 0; c < 150 && !fin; c++) begin
      tick(en, 1'b0);
      total++;
      if (obs0 !== exp0()) begin
        bad++;
        $display("FAIL full_cycle c=%0d got=%h want=%h", c, obs0, exp0());
      end
      if (s0) strobes.push_back(c);
      if (dn0) begin
        done_at = c;
        en = 1'b0;
      end else if (done_at >= 0) begin
        fin = 1'b1;
      end
    end
    total++;
    if (strobes.size() != 10) begin
      bad++;
      $display("FAIL full_strobe_count got=%0d want=10", strobes.size());
    end
    for (int k = 0; k < strobes.size() && k < 10; k++) begin
      total++;
      if (strobes[k] != 4 + 10 * k) begin
        bad++;
        $display("FAIL full_strobe_edge k=%0d got=%0d want=%0d", k, strobes[k], 4 + 10 * k);
      end
    end
    total++;
    if (done_at != 95) begin
      bad++;
      $display("FAIL full_done_edge got=%0d want=95", done_at);
    end
  endtask

  task automatic test_abort();
    int cnt, abort_at, late;
    logic en;
    cnt = 0; abort_at = -1; late = 0;
    for (int c = 0; c < 60; c++) begin
      en = (abort_at >= 0 && c >= abort_at) ? 1'b0 : 1'b1;
      tick(en, 1'b0);
      total++;
      if (obs0 !== exp0()) begin
        bad++;
        $display("FAIL abort_cycle c=%0d got=%h want=%h", c, obs0, exp0());
      end
      if (abort_at >= 0 && c >= abort_at && (s0 || dn0)) late++;
      if (c == abort_at) begin
        total++;
        if (i0 !== 4'd0) begin
          bad++;
          $display("FAIL abort_index got=%0d want=0", i0);
        end
      end
      if (s0 && abort_at < 0) begin
        cnt++;
        if (cnt == 3) abort_at = c + 3;
      end
    end
    total++;
    if (cnt != 3 || late != 0) begin
      bad++;
      $display("FAIL abort_activity strobes=%0d late=%0d want 3/0", cnt, late);
    end
  endtask

  task automatic test_reset_mid();
    int  first;
    bit  fin;
    for (int c = 0; c <= 40; c++) begin
      tick(1'b1, 1'b0);
      total++;
      if (obs0 !== exp0()) begin
        bad++;
        $display("FAIL rmid_pre c=%0d got=%h want=%h", c, obs0, exp0());
      end
    end
    #2 rst = 1'b1;
    ph0 = -1; ph1 = -1;
    #1;
    total++;
    if (obs0 !== 10'd0) begin
      bad++;
      $display("FAIL rmid_async got=%h want=000", obs0);
    end
    #1 rst = 1'b0;
    first = -1; fin = 1'b0;
    for (int c = 0; c < 120 && !fin; c++) begin
      tick(1'b1, 1'b0);
      total++;
      if (obs0 !== exp0()) begin
        bad++;
        $display("FAIL rmid_post c=%0d got=%h want=%h", c, obs0, exp0());
      end
      if (s0 && first < 0) first = c;
      if (dn0) fin = 1'b1;
    end
    tick(1'b0, 1'b0);
    total++;
    if (first != 4 || !fin) begin
      bad++;
      $display("FAIL rmid_first_strobe got=%0d done=%0d want=4/1", first, fin);
    end
  endtask

  task automatic test_back_to_back();
    int strobes[$];
    int dones[$];
    for (int c = 0; c < 194; c++) begin
      tick(1'b1, 1'b0);
      total++;
      if (obs0 !== exp0()) begin
        bad++;
        $display("FAIL b2b_cycle c=%0d got=%h want=%h", c, obs0, exp0());
      end
      if (s0) strobes.push_back(c);
      if (dn0) dones.push_back(c);
      if (c == 96) begin
        total++;
        if (obs0 !== 10'd0) begin
          bad++;
          $display("FAIL b2b_idle_gap got=%h want=000", obs0);
        end
      end
    end
    tick(1'b0, 1'b0);
    total++;
    if (strobes.size() != 20 || dones.size() != 2) begin
      bad++;
      $display("FAIL b2b_counts strobes=%0d dones=%0d want 20/2", strobes.size(), dones.size());
    end else begin
      for (int k = 0; k < 10; k++) begin
        total++;
        if (strobes[k + 10] != strobes[k] + 97) begin
          bad++;
          $display("FAIL b2b_spacing k=%0d got=%0d want=%0d", k, strobes[k + 10], strobes[k] + 97);
        end
      end
      total++;
      if (dones[0] != 95 || dones[1] != 192) begin
        bad++;
        $display("FAIL b2b_done got=%0d,%0d want=95,192", dones[0], dones[1]);
      end
    end
  endtask

  task automatic test_sweep();
    int   strobes[$];
    int   done_at;
    logic en;
    bit   fin;
    en = 1'b1; done_at = -1; fin = 1'b0;
    for (int c = 0; c < 40 && !fin; c++) begin
      tick(1'b0, en);
      total++;
      if (obs1 !== exp1()) begin
        bad++;
        $display("FAIL sweep_cycle c=%0d got=%h want=%h", c, obs1, exp1());
      end
      if (s1) strobes.push_back(c);
      if (dn1) begin
        done_at = c;
        en = 1'b0;
      end else if (done_at >= 0) begin
        fin = 1'b1;
      end
    end
    total++;
    if (strobes.size() != 3 || done_at != 12) begin
      bad++;
      $display("FAIL sweep_counts strobes=%0d done=%0d want 3/12", strobes.size(), done_at);
    end else begin
      for (int k = 0; k < 3; k++) begin
        total++;
        if (strobes[k] != 3 + 4 * k) begin
          bad++;
          $display("FAIL sweep_strobe_edge k=%0d got=%0d want=%0d", k, strobes[k], 3 + 4 * k);
        end
      end
    end
  endtask

  task automatic test_random();
    logic e0, e1;
    e0 = 1'b0; e1 = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 7) == 0) e0 = ~e0;
      if ($urandom_range(0, 7) == 0) e1 = ~e1;
      if ($urandom_range(0, 149) == 0) begin
        #2 rst = 1'b1;
        ph0 = -1; ph1 = -1;
        #2 rst = 1'b0;
      end
      tick(e0, e1);
      total++;
      if (obs0 !== exp0() || obs1 !== exp1()) begin
        bad++;
        $display("FAIL random c=%0d got=%h/%h want=%h/%h", c, obs0, obs1, exp0(), exp1());
      end
    end
    tick(1'b0, 1'b0);
    repeat (20) tick(1'b0, 1'b0);
  endtask

  initial begin
    total = 0; bad = 0;
    ph0 = -1; ph1 = -1;
    en0 = 1'b0; en1 = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_full_packet();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_sweep();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rcv_bit_timer.md
# rcv_bit_timer

Bit-timing controller for the serial receive path. While enabled, it tracks clock cycles within each bit period and emits a one-cycle sample strobe at a fixed point inside every bit. It counts the sampled bits and pulses a done flag after a full packet. It sits between the start-bit detector, which drives `enable_timer`, and the receive shift register and receiver FSM, which consume `shift_strobe` and `packet_done`.

## Interface
- `CLKS_PER_BIT`, default 10: clock cycles per serial bit; legal range ≥ 2.
- `SAMPLE_POINT`, default 5: cycle within a bit (1-based) at which the strobe fires; legal range 1..`CLKS_PER_BIT`.
- `BITS_PER_PACKET`, default 10: bits per packet (start + 8 data + stop); legal range ≥ 1.
- `clk` input, 1 bit: system clock; all state changes on the rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `enable_timer` input, 1 bit: level request to run the timer; owned by the upstream controller.
- `shift_strobe` output, 1 bit: one-cycle pulse at each bit's sample point.
- `packet_done` output, 1 bit: one-cycle pulse after the last bit of a packet is sampled.
- `bit_index` output, $clog2(`BITS_PER_PACKET`+1) bits: number of bits sampled so far in the current packet.

## Operation
- Internal state:
  - FSM with states IDLE, RUN, DONE.
  - `clk_cnt`, width $clog2(`CLKS_PER_BIT`+1).
  - `bit_cnt`, width $clog2(`BITS_PER_PACKET`+1).
- Counter convention: `clk_cnt` counts 1..`CLKS_PER_BIT`, then wraps to 1 (rollover-to-1, never 0 while running).
- IDLE:
  - `clk_cnt` = 0, `bit_cnt` = 0.
  - On an edge with `enable_timer`=1: go to RUN, `clk_cnt` ← 1, `bit_cnt` ← 0.
- RUN, on each edge:
  - If `enable_timer`=0: go to IDLE and clear both counters. Abort has priority over all other updates, including a strobe in the same cycle.
  - Otherwise, `clk_cnt` ← 1 if `clk_cnt` = `CLKS_PER_BIT`, else `clk_cnt`+1.
  - If `shift_strobe`=1 on that edge, `bit_cnt` ← `bit_cnt`+1.
  - If `shift_strobe`=1 and `bit_cnt` = `BITS_PER_PACKET`−1: go to DONE instead, with `bit_cnt` ← `BITS_PER_PACKET` and `clk_cnt` ← 0.
- DONE:
  - Lasts exactly one cycle, then IDLE unconditionally; counters clear on that edge.
  - `enable_timer` is ignored in DONE.
  - If upstream still holds `enable_timer`=1 in IDLE, a new packet starts on the next edge. Upstream must deassert `enable_timer` on `packet_done` to avoid this.
- Output decode (combinational from registered state only; no input-to-output paths):
  - `shift_strobe` = (state==RUN) && (`clk_cnt`==`SAMPLE_POINT`).
  - `packet_done` = (state==DONE).
  - `bit_index` = `bit_cnt`.
- Reset (`rst`=1, asynchronous): state IDLE, both counters 0. Outputs are immediately `shift_strobe`=0, `packet_done`=0, `bit_index`=0. Reset mid-packet discards all progress.

## Timing
- Let E0 be the first edge with `enable_timer`=1 in IDLE. After E0: RUN, `clk_cnt`=1.
- First strobe: high during the cycle after edge E(`SAMPLE_POINT`−1). Defaults: after E4, low again after E5.
- Strobe k (1-based) is high after edge E(`SAMPLE_POINT`−1+(k−1)·`CLKS_PER_BIT`). Defaults: E4, E14, ..., E94.
- `packet_done` is high for the single cycle after edge E(`SAMPLE_POINT`+(`BITS_PER_PACKET`−1)·`CLKS_PER_BIT`). Defaults: E95 to E96. IDLE follows at E96.
- `bit_index` steps on the edge ending each strobe. It reads `BITS_PER_PACKET` during DONE and returns to 0 at the next edge.
- Strobe spacing is exactly `CLKS_PER_BIT` cycles. No strobe occurs in IDLE or DONE.
- `SAMPLE_POINT`=`CLKS_PER_BIT`: the strobe coincides with the wrap cycle; the same rules apply.

## Test plan
- Reset/idle: assert `rst` asynchronously mid-cycle, then hold `enable_timer`=0 for 20 cycles.
  - Required: all outputs 0 immediately on reset and throughout.
- Full packet, defaults: raise `enable_timer` before E0 and hold it until `packet_done`.
  - Required: exactly 10 strobes, at the cycles after E4, E14, ..., E94.
  - Required: `bit_index` reads 1..9 between strobes, then 10 during `packet_done` (after E95 only), then 0 at E96.
- Abort: deassert `enable_timer` 2 cycles after the third strobe.
  - Required: IDLE on the next edge, `bit_index`=0, no further strobes, no `packet_done`.
- Reset mid-packet: pulse `rst` between E40 and E41.
  - Required: outputs 0 at once.
  - Required: after `rst` falls with `enable_timer` still 1, a fresh packet starts with its first strobe 5 cycles later.
- Back-to-back packets: hold `enable_timer`=1 through `packet_done`.
  - Required: one IDLE cycle after DONE, then a second packet with identical strobe timing.
- Parameter sweep: `CLKS_PER_BIT`=4, `SAMPLE_POINT`=4, `BITS_PER_PACKET`=3.
  - Required: strobes after E3, E7, E11; `packet_done` after E12.
